// File: rtl/spi_xfer_fifo.sv
// -----------------------------------------------------------------------------
// spi_xfer_fifo
//
// Word-level buffering between the host and the SPI controller, all in the
// core_clk domain. A TX queue holds host words and a small launch FSM hands
// them to the controller one at a time. An RX queue captures each received
// controller word for the host to drain with a valid/ready handshake.
//
// Optional feature (compile-time macro SPI_XFER_FIFO_OVF_EN):
//   defined   - rx_overflow is a sticky flag set on every dropped RX word and
//               cleared by err_clr (a same-cycle drop wins over the clear).
//   undefined - rx_overflow is tied to 0 and dropped words vanish silently.
//
// Ports:
//   core_clk     in   single clock, rising edge
//   arst_n       in   synchronous active-low reset
//   flush        in   synchronous clear of both queues, FSM back to IDLE
//   err_clr      in   clears rx_overflow
//   h_wdata      in   host transmit word
//   h_wvalid     in   host transmit word valid
//   h_wready     out  TX queue not full
//   h_rdata      out  RX head (0 when h_rvalid low)
//   h_rvalid     out  RX queue not empty
//   h_rready     in   host consumes RX head
//   c_tx_data    out  word offered to the controller (0 when c_tx_valid low)
//   c_tx_valid   out  word offered to the controller
//   c_busy       in   controller busy
//   c_rx_data    in   controller received word
//   c_rx_valid   in   single-cycle received-word strobe
//   c_rx_ready   out  RX queue not full (informational only)
//   tx_level     out  TX occupancy 0..DEPTH
//   rx_level     out  RX occupancy 0..DEPTH
//   rx_overflow  out  sticky RX drop flag
// -----------------------------------------------------------------------------
module spi_xfer_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int LW     = $clog2(DEPTH) + 1
) (
    input  logic              core_clk,
    input  logic              arst_n,
    input  logic              flush,
    input  logic              err_clr,
    input  logic [DATA_W-1:0] h_wdata,
    input  logic              h_wvalid,
    output logic              h_wready,
    output logic [DATA_W-1:0] h_rdata,
    output logic              h_rvalid,
    input  logic              h_rready,
    output logic [DATA_W-1:0] c_tx_data,
    output logic              c_tx_valid,
    input  logic              c_busy,
    input  logic [DATA_W-1:0] c_rx_data,
    input  logic              c_rx_valid,
    output logic              c_rx_ready,
    output logic [LW-1:0]     tx_level,
    output logic [LW-1:0]     rx_level,
    output logic              rx_overflow
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_WAIT_BUSY = 2'b01,
        ST_ACTIVE    = 2'b10
    } tx_state_e;

    // ---------------------------------------------------------------------
    // Storage and pointers. Pointers carry one wrap bit above the index so
    // that full and empty are distinguishable with equal indices.
    // ---------------------------------------------------------------------
    logic [DATA_W-1:0] tx_mem_r [DEPTH];
    logic [DATA_W-1:0] rx_mem_r [DEPTH];
    logic [LW-1:0]     tx_wr_ptr_r;
    logic [LW-1:0]     tx_rd_ptr_r;
    logic [LW-1:0]     rx_wr_ptr_r;
    logic [LW-1:0]     rx_rd_ptr_r;

    tx_state_e         tx_state_r;
    tx_state_e         tx_state_nxt_s;

    logic              tx_full_s;
    logic              tx_empty_s;
    logic              rx_full_s;
    logic              rx_empty_s;
    logic              tx_push_s;
    logic              tx_pop_s;
    logic              rx_push_s;
    logic              rx_pop_s;
    logic              rx_drop_s;
    logic              tx_valid_s;
    logic [DATA_W-1:0] tx_head_s;
    logic [DATA_W-1:0] rx_head_s;

    assign tx_empty_s = (tx_wr_ptr_r == tx_rd_ptr_r);
    assign tx_full_s  = (tx_wr_ptr_r[AW-1:0] == tx_rd_ptr_r[AW-1:0]) &&
                        (tx_wr_ptr_r[AW] != tx_rd_ptr_r[AW]);
    assign rx_empty_s = (rx_wr_ptr_r == rx_rd_ptr_r);
    assign rx_full_s  = (rx_wr_ptr_r[AW-1:0] == rx_rd_ptr_r[AW-1:0]) &&
                        (rx_wr_ptr_r[AW] != rx_rd_ptr_r[AW]);

    assign tx_head_s  = tx_mem_r[tx_rd_ptr_r[AW-1:0]];
    assign rx_head_s  = rx_mem_r[rx_rd_ptr_r[AW-1:0]];

    // Acceptance is decided on current occupancy only: a same-cycle pop never
    // opens room for a push into a full queue. Flush and reset cancel all
    // queue traffic for the cycle.
    assign tx_push_s  = arst_n && !flush && h_wvalid && !tx_full_s;
    assign rx_push_s  = arst_n && !flush && c_rx_valid && !rx_full_s;
    assign rx_drop_s  = arst_n && !flush && c_rx_valid && rx_full_s;
    assign rx_pop_s   = arst_n && !flush && !rx_empty_s && h_rready;

    // ---------------------------------------------------------------------
    // TX launch FSM
    // ---------------------------------------------------------------------

    // Launch FSM state register; flush returns it to IDLE.
    always_ff @(posedge core_clk) begin
        if (!arst_n) begin
            tx_state_r <= ST_IDLE;
        end else if (flush) begin
            tx_state_r <= ST_IDLE;
        end else begin
            tx_state_r <= tx_state_nxt_s;
        end
    end

    // Launch FSM next state, offer valid and head pop. The head is popped on
    // the first busy cycle after the offer, which keeps the word stable for
    // the whole offer window.
    always_comb begin
        tx_state_nxt_s = tx_state_r;
        tx_valid_s     = 1'b0;
        tx_pop_s       = 1'b0;
        case (tx_state_r)
            ST_IDLE: begin
                // After a reset mid-transfer c_busy may still be high; the
                // !c_busy term holds off the next word until it drops.
                tx_valid_s = !tx_empty_s && !c_busy;
                if (tx_valid_s) begin
                    tx_state_nxt_s = ST_WAIT_BUSY;
                end else begin
                    tx_state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT_BUSY: begin
                tx_valid_s = 1'b1;
                if (c_busy) begin
                    tx_pop_s       = arst_n && !flush;
                    tx_state_nxt_s = ST_ACTIVE;
                end else begin
                    tx_state_nxt_s = ST_WAIT_BUSY;
                end
            end
            ST_ACTIVE: begin
                tx_valid_s = 1'b0;
                if (!c_busy) begin
                    tx_state_nxt_s = ST_IDLE;
                end else begin
                    tx_state_nxt_s = ST_ACTIVE;
                end
            end
            default: begin
                tx_valid_s     = 1'b0;
                tx_state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Pointer registers
    // ---------------------------------------------------------------------

    // TX pointers: advance on push/pop, cleared by reset and flush.
    always_ff @(posedge core_clk) begin
        if (!arst_n) begin
            tx_wr_ptr_r <= {LW{1'b0}};
            tx_rd_ptr_r <= {LW{1'b0}};
        end else if (flush) begin
            tx_wr_ptr_r <= {LW{1'b0}};
            tx_rd_ptr_r <= {LW{1'b0}};
        end else begin
            if (tx_push_s) begin
                tx_wr_ptr_r <= tx_wr_ptr_r + LW'(1);
            end
            if (tx_pop_s) begin
                tx_rd_ptr_r <= tx_rd_ptr_r + LW'(1);
            end
        end
    end

    // RX pointers: advance on push/pop, cleared by reset and flush.
    always_ff @(posedge core_clk) begin
        if (!arst_n) begin
            rx_wr_ptr_r <= {LW{1'b0}};
            rx_rd_ptr_r <= {LW{1'b0}};
        end else if (flush) begin
            rx_wr_ptr_r <= {LW{1'b0}};
            rx_rd_ptr_r <= {LW{1'b0}};
        end else begin
            if (rx_push_s) begin
                rx_wr_ptr_r <= rx_wr_ptr_r + LW'(1);
            end
            if (rx_pop_s) begin
                rx_rd_ptr_r <= rx_rd_ptr_r + LW'(1);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Storage arrays (not reset; outputs are masked while invalid)
    // ---------------------------------------------------------------------

    // TX storage write port.
    always_ff @(posedge core_clk) begin
        if (tx_push_s) begin
            tx_mem_r[tx_wr_ptr_r[AW-1:0]] <= h_wdata;
        end
    end

    // RX storage write port.
    always_ff @(posedge core_clk) begin
        if (rx_push_s) begin
            rx_mem_r[rx_wr_ptr_r[AW-1:0]] <= c_rx_data;
        end
    end

    // ---------------------------------------------------------------------
    // Overflow flag
    // ---------------------------------------------------------------------
`ifdef SPI_XFER_FIFO_OVF_EN
    logic rx_overflow_r;

    // Sticky drop flag; a drop in the same cycle as err_clr keeps it set.
    always_ff @(posedge core_clk) begin
        if (!arst_n) begin
            rx_overflow_r <= 1'b0;
        end else if (rx_drop_s) begin
            rx_overflow_r <= 1'b1;
        end else if (err_clr) begin
            rx_overflow_r <= 1'b0;
        end else begin
            rx_overflow_r <= rx_overflow_r;
        end
    end

    assign rx_overflow = rx_overflow_r;
`else
    // Flag removed: the clear input and drop detect have no load.
    logic ovf_unused_s;
    assign ovf_unused_s = err_clr ^ rx_drop_s;
    assign rx_overflow  = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign h_wready   = !tx_full_s;
    assign c_rx_ready = !rx_full_s;
    assign h_rvalid   = !rx_empty_s;
    assign h_rdata    = h_rvalid ? rx_head_s : {DATA_W{1'b0}};
    assign c_tx_valid = tx_valid_s;
    assign c_tx_data  = tx_valid_s ? tx_head_s : {DATA_W{1'b0}};
    // Modular subtraction stays correct across pointer wrap.
    assign tx_level   = tx_wr_ptr_r - tx_rd_ptr_r;
    assign rx_level   = rx_wr_ptr_r - rx_rd_ptr_r;

endmodule
